// File: rtl/next_pc_unit_if.sv
// rtl/next_pc_unit_if.sv - fetch-side bundle between the core datapath and the next-PC unit
interface next_pc_if #(
    parameter int ADDR_W = 32
);
    logic              stall;
    logic [31:0]       instruction;
    logic              zero;
    logic [ADDR_W-1:0] jr_target;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] link_addr;
    logic              halted;
    logic              ras_overflow;
    logic              ras_underflow;

    modport master (
        output stall, instruction, zero, jr_target,
        input  pc, pc_next, link_addr, halted, ras_overflow, ras_underflow
    );

    modport slave (
        input  stall, instruction, zero, jr_target,
        output pc, pc_next, link_addr, halted, ras_overflow, ras_underflow
    );
endinterface

// File: rtl/next_pc_unit.sv
// rtl/next_pc_unit.sv - PC register, j/jal/beq/bne/jr decode, return-address stack and sticky halt
module next_pc_unit #(
    parameter int ADDR_W      = 32,
    parameter int RESET_PC    = 0,
    parameter int HALT_PC     = 17,
    parameter int ENABLE_HALT = 1,
    parameter int RAS_DEPTH   = 4
) (
    input logic      clk,
    input logic      rst,
    next_pc_if.slave bus
);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [ADDR_W-1:0] HALT_LIM = ADDR_W'(HALT_PC);
    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] FN_JR      = 6'b001000;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              halted_q, halted_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic [PTR_W-1:0]  top_q, top_d, top_inc, top_dec;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] ras_q [RAS_DEPTH];

    logic [5:0]        opcode, funct;
    logic [4:0]        rs;
    logic [ADDR_W+25:0] j_ext;
    logic [ADDR_W+15:0] off_ext;
    logic [ADDR_W-1:0] pc_plus1, jump_tgt, br_tgt, ras_top, target, pc_next;
    logic              is_push, is_pop, ras_wr;

    assign opcode   = bus.instruction[31:26];
    assign funct    = bus.instruction[5:0];
    assign rs       = bus.instruction[25:21];
    assign j_ext    = {{ADDR_W{1'b0}}, bus.instruction[25:0]};
    assign jump_tgt = j_ext[ADDR_W-1:0];
    assign off_ext  = {{ADDR_W{bus.instruction[15]}}, bus.instruction[15:0]};
    assign pc_plus1 = pc_q + ADDR_W'(1);
    assign br_tgt   = pc_plus1 + off_ext[ADDR_W-1:0];
    assign ras_top  = ras_q[top_q];
    // Pointer wraps explicitly so non-power-of-two depths stay circular
    assign top_inc  = (top_q == PTR_W'(RAS_DEPTH - 1)) ? '0 : top_q + PTR_W'(1);
    assign top_dec  = (top_q == '0) ? PTR_W'(RAS_DEPTH - 1) : top_q - PTR_W'(1);

    always_comb begin
        target  = pc_plus1;
        is_push = 1'b0;
        is_pop  = 1'b0;
        case (opcode)
            OP_J:   target = jump_tgt;
            OP_JAL: begin
                target  = jump_tgt;
                is_push = 1'b1;
            end
            OP_BEQ: if (bus.zero)  target = br_tgt;
            OP_BNE: if (!bus.zero) target = br_tgt;
            OP_SPECIAL: begin
                if (funct == FN_JR) begin
                    if (rs == 5'd31) begin
                        is_pop = 1'b1;
                        target = (cnt_q != '0) ? ras_top : bus.jr_target;
                    end else begin
                        target = bus.jr_target;
                    end
                end
            end
            default: ;
        endcase
    end

    assign pc_next = (halted_q || bus.stall) ? pc_q : target;

    always_comb begin
        pc_d     = pc_q;
        halted_d = halted_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        top_d    = top_q;
        cnt_d    = cnt_q;
        ras_wr   = 1'b0;
        if (!bus.stall && !halted_q) begin
            // Halt swallows the offending transfer entirely, RAS included
            if ((ENABLE_HALT != 0) && (pc_next > HALT_LIM)) begin
                halted_d = 1'b1;
            end else begin
                pc_d = pc_next;
                if (is_push) begin
                    ras_wr = 1'b1;
                    top_d  = top_inc;
                    if (cnt_q == CNT_W'(RAS_DEPTH)) ovf_d = 1'b1;
                    else                            cnt_d = cnt_q + CNT_W'(1);
                end else if (is_pop) begin
                    if (cnt_q != '0) begin
                        top_d = top_dec;
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        unf_d = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= ADDR_W'(RESET_PC);
            halted_q <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            top_q    <= '0;
            cnt_q    <= '0;
        end else begin
            pc_q     <= pc_d;
            halted_q <= halted_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            top_q    <= top_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ras_wr && !rst) ras_q[top_inc] <= pc_plus1;
    end

    assign bus.pc            = pc_q;
    assign bus.pc_next       = pc_next;
    assign bus.link_addr     = pc_plus1;
    assign bus.halted        = halted_q;
    assign bus.ras_overflow  = ovf_q;
    assign bus.ras_underflow = unf_q;
endmodule

// File: doc/next_pc_unit.md
Name: next_pc_unit

Overview:
- Parametrised next-PC generator for the single-cycle core. Replaces the fixed 32-bit jump/beq-only sequencer.
- Holds the architectural PC register and decodes j / jal / beq / bne / jr from the fetched instruction.
- Adds a stall input, a bounded return-address stack (RAS) for jal / jr $ra, and a sticky halt state that replaces simulation-only termination.
- Sits between instruction memory (drives its address) and the register-file/ALU flags.

Parameters:
- ADDR_W, 32, PC width in words; all PC arithmetic is modulo 2^ADDR_W.
- RESET_PC, 0, PC value loaded on reset.
- HALT_PC, 17, halt is entered when a computed next PC exceeds this value (unsigned compare).
- ENABLE_HALT, 1, 0 disables halt detection entirely.
- RAS_DEPTH, 4, number of RAS entries; must be 2 or more.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  1 = hold PC; suppresses all RAS updates.
- instruction  in  32  instruction at the current pc.
- zero  in  1  ALU equality flag for the current instruction (1 = rs==rt).
- jr_target  in  ADDR_W  register-file value of rs, used for jr.
- pc  out  ADDR_W  registered fetch address.
- pc_next  out  ADDR_W  combinational address that will load on the next edge.
- link_addr  out  ADDR_W  pc+1; register-file write data for jal.
- halted  out  1  sticky halt flag.
- ras_overflow  out  1  sticky flag: a push occurred while the RAS was full.
- ras_underflow  out  1  sticky flag: a jr $ra occurred while the RAS was empty.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): pc=RESET_PC, halted=0, both RAS flags=0, RAS count=0. Reset wins over stall, halt and any instruction, including mid-stall.
- Decode uses opcode = instruction[31:26].
  - 000010 j: target = instruction[25:0], zero-extended or truncated to ADDR_W.
  - 000011 jal: same target as j; pushes pc+1 onto the RAS.
  - 000100 beq: taken if zero=1; target = pc+1+sext(instruction[15:0]).
  - 000101 bne: taken if zero=0; same target as beq.
  - opcode 000000 with funct instruction[5:0]=001000 is jr:
    - rs=31 (jr $ra): pops the RAS and jumps to the popped value. If the RAS is empty, jumps to jr_target and sets ras_underflow.
    - rs≠31: jumps to jr_target; the RAS is untouched.
  - Any other instruction, or a branch not taken: pc+1.
- pc_next:
  - equals pc whenever halted=1 or stall=1;
  - otherwise equals the decoded target.
  - It is purely combinational from pc, instruction, zero, jr_target, RAS top, stall and halted.
- Clock edge with no rst, stall=0, halted=0:
  - If ENABLE_HALT=1 and pc_next > HALT_PC: pc holds, halted<=1, no RAS update.
  - Otherwise: pc<=pc_next and the RAS push/pop is applied.
- halted=1: pc frozen; state leaves only via rst.
- RAS implementation: circular buffer with a top pointer and a count of 0..RAS_DEPTH.
  - Push when full: overwrites the oldest entry, count stays RAS_DEPTH, ras_overflow<=1.
  - Pop: count decrements and the top pointer retreats.
  - After an overflow, the newest RAS_DEPTH return addresses remain correct.
- link_addr = pc+1 at all times, including wrap-around (pc=2^ADDR_W-1 gives 0).
- Branch offset arithmetic wraps modulo 2^ADDR_W. Negative offsets are legal.
- Latency:
  - pc_next is valid in the same cycle the instruction is presented.
  - pc updates on the following edge.
  - RAS state is visible in the cycle after the edge.

Test Plan:
- Reset then 3 nops, no stall -> pc sequence 0,1,2,3; link_addr=pc+1 each cycle; halted=0.
- beq at pc=5 with offset 0xFFFE: zero=1 -> pc_next=4; zero=0 -> pc_next=6. bne at pc=5 with offset 0x0003: zero=0 -> pc_next=9; zero=1 -> pc_next=6.
- jal (0x0C00000A) at pc=2 -> pc=10, link_addr was 3. Then jr $ra (0x03E00008) -> pc=3, RAS count 0, no flags set.
- RAS_DEPTH=4: five nested jal at pc=1,11,21,31,41 -> ras_overflow=1. The first four jr $ra return to 42,32,22,12. The fifth sees an empty RAS: jumps to jr_target=0x7 and sets ras_underflow=1.
- HALT_PC=17, sequential code from 15 -> pc 15,16,17, then halted=1 and pc stays 17 for 5 more cycles. A subsequent rst -> pc=0, halted=0.
- stall=1 for 3 cycles with a jal presented -> pc and RAS count unchanged, pc_next=pc. rst asserted during the stall -> pc=RESET_PC on that edge.
